// File: rtl/axi_arb_pkg.sv
// Shared constants for the AXI single-read-port arbiter: FSM encoding and the
// default data word returned when a read times out.
package axi_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Bundle of requester-side and AXI_master-side signals around the read arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface axi_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_error;
  logic                      busy;
  logic                      read_request;
  logic [ADDR_W-1:0]         read_address;
  logic [DATA_W-1:0]         value_read;
  logic                      data_available;

  modport slave (
    input  req_valid, req_addr, value_read, data_available,
    output req_ready, rsp_valid, rsp_data, rsp_error, busy,
           read_request, read_address
  );

  modport master (
    output req_valid, req_addr, value_read, data_available,
    input  req_ready, rsp_valid, rsp_data, rsp_error, busy,
           read_request, read_address
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last',
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  assign any = |req;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    gnt_idx = '0;
    for (int off = N; off >= 1; off--) begin
      if (req[(int'(last) + off) % N]) begin
        gnt_idx = IW'((int'(last) + off) % N);
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares AXI_master's single read port among NUM_REQ requesters: round-robin
// grant, one read in flight, per-read timeout returning ERR_DATA.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int               NUM_REQ  = 4,
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEFAULT_ERR_DATA)
) (
  input  logic               clk,
  input  logic               rst,
  axi_read_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant_oh;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req     (bus.req_valid),
    .last    (last_q),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_arr[gi]      = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign grant_oh[gi]      = (grant_q == IW'(gi));
    assign bus.req_ready[gi] = (state_q == ST_ISSUE) && grant_oh[gi];
    assign bus.rsp_valid[gi] = (state_q == ST_RESP) && grant_oh[gi];
  end

  assign bus.read_request = (state_q == ST_ISSUE);
  assign bus.read_address = addr_q;
  assign bus.rsp_data     = data_q;
  assign bus.rsp_error    = err_q;
  assign bus.busy         = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          addr_d  = addr_arr[arb_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Real data takes priority over a timeout landing on the same cycle.
        if (bus.data_available) begin
          data_d  = bus.value_read;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          data_d  = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q starts at NUM_REQ-1 so requester 0 is first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      timer_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: scoreboard of expected responses,
// one task per scenario.
module tb_axi_read_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NR-1:0] valid;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int rr_count = 0;

  always @(negedge clk) if (bus.read_request === 1'b1) rr_count++;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [AW-1:0] addr_of(input int g);
    return 32'h4000_0010 + 32'(g) * 32'h100;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    bus.data_available = 1'b0;
    bus.value_read = '0;
    for (int g = 0; g < NR; g++) bus.req_addr[g*AW +: AW] = addr_of(g);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.read_request === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic master_pulse(input logic [DW-1:0] v);
    bus.value_read = v;
    bus.data_available = 1'b1;
    @(negedge clk);
    bus.data_available = 1'b0;
    bus.value_read = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.read_request !== 1'b0) begin bad++; $display("FAIL reset_rreq got=%b want=0", bus.read_request); end
    total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.req_ready); end
    total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", bus.rsp_data); end
    total++; if (bus.rsp_error !== 1'b0) begin bad++; $display("FAIL reset_rsp_error got=%b want=0", bus.rsp_error); end
    total++; if (bus.read_address !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.read_address); end
  endtask

  task automatic test_single();
    exp_t e;
    bit ok;
    apply_reset();
    bus.req_valid = 4'b0001;
    exp_q.push_back('{4'b0001, 32'h1234_5678, 1'b0});
    wait_rr(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_rreq got=none want=pulse"); end
    total++; if (bus.read_address !== 32'h4000_0010) begin bad++; $display("FAIL single_addr got=%h want=40000010", bus.read_address); end
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge clk);
    total++; if (bus.read_request !== 1'b0) begin bad++; $display("FAIL single_rreq_len got=%b want=0", bus.read_request); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus.busy); end
    repeat (3) @(negedge clk);
    master_pulse(32'h1234_5678);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL single_sb got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      $display("txn single: v=%b d=%h e=%b", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
      if (bus.rsp_valid !== e.valid || bus.rsp_data !== e.data || bus.rsp_error !== e.err) begin
        bad++; $display("FAIL single_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_error, e.valid, e.data, e.err);
      end
    end
    total++; if (bus.read_address !== 32'h4000_0010) begin bad++; $display("FAIL single_addr_hold got=%h want=40000010", bus.read_address); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin bad++; $display("FAIL single_idle got busy=%b v=%b want 0/0", bus.busy, bus.rsp_valid); end
    total++; if (bus.rsp_data !== 32'h1234_5678) begin bad++; $display("FAIL single_hold got=%h want=12345678", bus.rsp_data); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit ok;
    int start;
    int g;
    logic [NR-1:0] oh;
    apply_reset();
    start = rr_count;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = i % NR;
      oh = '0;
      oh[g] = 1'b1;
      exp_q.push_back('{oh, 32'hC0DE_0000 + 32'(i), 1'b0});
      wait_rr(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_rreq[%0d] got=none want=pulse", i); end
      total++; if (bus.req_ready !== oh) begin bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", i, bus.req_ready, oh); end
      total++; if (bus.read_address !== addr_of(g)) begin bad++; $display("FAIL rr_addr[%0d] got=%h want=%h", i, bus.read_address, addr_of(g)); end
      @(negedge clk);
      master_pulse(32'hC0DE_0000 + 32'(i));
      total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL rr_sb[%0d] got=empty want=entry", i); end
      else begin
        e = exp_q.pop_front();
        $display("txn rr[%0d]: v=%b d=%h e=%b", i, bus.rsp_valid, bus.rsp_data, bus.rsp_error);
        if (bus.rsp_valid !== e.valid || bus.rsp_data !== e.data || bus.rsp_error !== e.err) begin
          bad++; $display("FAIL rr_rsp[%0d] got v=%b d=%h e=%b want v=%b d=%h e=%b",
                          i, bus.rsp_valid, bus.rsp_data, bus.rsp_error, e.valid, e.data, e.err);
        end
      end
    end
    bus.req_valid = '0;
    @(negedge clk);
    total++; if (rr_count - start != 5) begin bad++; $display("FAIL rr_count got=%0d want=5", rr_count - start); end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit ok;
    int cyc;
    apply_reset();
    bus.req_valid = 4'b0100;
    exp_q.push_back('{4'b0100, 32'hDEAD_BEEF, 1'b1});
    wait_rr(ok);
    total++; if (!ok) begin bad++; $display("FAIL to_rreq got=none want=pulse"); end
    bus.req_valid = '0;
    wait_rsp(TO + 10, cyc);
    total++; if (cyc != TO + 1) begin bad++; $display("FAIL to_latency got=%0d want=%0d", cyc, TO + 1); end
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL to_sb got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      $display("txn timeout: v=%b d=%h e=%b", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
      if (bus.rsp_valid !== e.valid || bus.rsp_data !== e.data || bus.rsp_error !== e.err) begin
        bad++; $display("FAIL to_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_error, e.valid, e.data, e.err);
      end
    end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin bad++; $display("FAIL to_idle got busy=%b v=%b want 0/0", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    bit ok;
    apply_reset();
    bus.req_valid = 4'b0010;
    exp_q.push_back('{4'b0010, 32'hA5A5_A5A5, 1'b0});
    wait_rr(ok);
    total++; if (!ok) begin bad++; $display("FAIL edge_rreq got=none want=pulse"); end
    bus.req_valid = '0;
    repeat (TO) @(negedge clk);
    master_pulse(32'hA5A5_A5A5);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL edge_sb got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      $display("txn edge: v=%b d=%h e=%b", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
      if (bus.rsp_valid !== e.valid || bus.rsp_data !== e.data || bus.rsp_error !== e.err) begin
        bad++; $display("FAIL edge_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_error, e.valid, e.data, e.err);
      end
    end
  endtask

  task automatic test_spurious();
    exp_t e;
    bit ok;
    apply_reset();
    master_pulse(32'h1111_1111);
    total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin bad++; $display("FAIL spur_idle got busy=%b v=%b want 0/0", bus.busy, bus.rsp_valid); end
    bus.req_valid = 4'b1000;
    exp_q.push_back('{4'b1000, 32'h2222_2222, 1'b0});
    wait_rr(ok);
    total++; if (!ok) begin bad++; $display("FAIL spur_rreq got=none want=pulse"); end
    bus.req_valid = '0;
    master_pulse(32'h3333_3333);
    total++; if (bus.rsp_valid !== '0 || bus.busy !== 1'b1) begin bad++; $display("FAIL spur_issue got v=%b busy=%b want 0/1", bus.rsp_valid, bus.busy); end
    repeat (2) @(negedge clk);
    total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL spur_wait got v=%b want 0", bus.rsp_valid); end
    master_pulse(32'h2222_2222);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL spur_sb got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      $display("txn spurious: v=%b d=%h e=%b", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
      if (bus.rsp_valid !== e.valid || bus.rsp_data !== e.data || bus.rsp_error !== e.err) begin
        bad++; $display("FAIL spur_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_error, e.valid, e.data, e.err);
      end
    end
    @(negedge clk);
    master_pulse(32'h9999_9999);
    total++; if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin bad++; $display("FAIL spur_idle2 got v=%b busy=%b want 0/0", bus.rsp_valid, bus.busy); end
    total++; if (bus.rsp_data !== 32'h2222_2222) begin bad++; $display("FAIL spur_hold got=%h want=22222222", bus.rsp_data); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    apply_reset();
    bus.req_valid = 4'b0001;
    exp_q.push_back('{4'b0001, 32'h5555_0000, 1'b0});
    wait_rr(ok);
    bus.req_valid = '0;
    @(negedge clk);
    master_pulse(32'h5555_0000);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL rst_pre_sb got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      $display("txn rst_pre: v=%b d=%h e=%b", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
      if (bus.rsp_valid !== e.valid || bus.rsp_data !== e.data) begin
        bad++; $display("FAIL rst_pre_rsp got v=%b d=%h want v=%b d=%h", bus.rsp_valid, bus.rsp_data, e.valid, e.data);
      end
    end
    bus.req_valid = 4'b0010;
    wait_rr(ok);
    total++; if (!ok || bus.req_ready !== 4'b0010) begin bad++; $display("FAIL rst_grant1 got=%b want=0010", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.read_address !== '0) begin bad++; $display("FAIL rst_mid_state got busy=%b addr=%h want 0/0", bus.busy, bus.read_address); end
    total++; if (bus.rsp_data !== '0 || bus.rsp_error !== 1'b0) begin bad++; $display("FAIL rst_mid_rsp got d=%h e=%b want 0/0", bus.rsp_data, bus.rsp_error); end
    repeat (2) @(negedge clk);
    master_pulse(32'hBAD0_BAD0);
    total++; if (bus.rsp_valid !== '0 || bus.busy !== 1'b0 || bus.rsp_data !== '0) begin
      bad++; $display("FAIL rst_stale got v=%b busy=%b d=%h want 0/0/0", bus.rsp_valid, bus.busy, bus.rsp_data);
    end
    bus.req_valid = 4'b1111;
    exp_q.push_back('{4'b0001, 32'h6666_6666, 1'b0});
    wait_rr(ok);
    total++; if (!ok || bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rst_first_grant got=%b want=0001", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge clk);
    master_pulse(32'h6666_6666);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL rst_post_sb got=empty want=entry"); end
    else begin
      e = exp_q.pop_front();
      $display("txn rst_post: v=%b d=%h e=%b", bus.rsp_valid, bus.rsp_data, bus.rsp_error);
      if (bus.rsp_valid !== e.valid || bus.rsp_data !== e.data || bus.rsp_error !== e.err) begin
        bad++; $display("FAIL rst_post_rsp got v=%b d=%h e=%b want v=%b d=%h e=%b",
                        bus.rsp_valid, bus.rsp_data, bus.rsp_error, e.valid, e.data, e.err);
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.value_read = '0;
    bus.data_available = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_same_cycle();
    test_spurious();
    test_reset_mid();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
